alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between NUM_REQ requesters (e.g. execute stage, address-gen, debug unit).

---
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ requesters, one op in flight, valid/ready response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [3:0]                alu_ctrl,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      alu_carry,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_carry,
    output logic                      rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     start, win_idx, id_q, id_d, rsp_id_q, rsp_id_d;
    logic                win_found;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
    logic [3:0]          alu_ctrl_q, alu_ctrl_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    // Pointer moves just past the winner, only when a request actually transfers
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_found)
            ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Round-robin pointer register; requester 0 has top priority after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end
`endif

    // Find the first valid requester starting at 'start', wrapping at NUM_REQ
    always_comb begin
        logic [ID_W:0] pos;
        pos       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ))
                pos = pos - (ID_W+1)'(NUM_REQ);
            if (req_valid[pos[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[ID_W-1:0];
            end
        end
    end

    // FSM next state, grant, operand issue and response capture
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        req_ready   = '0;
        case (state_q)
            IDLE: if (win_found) begin
                req_ready  = {NUM_REQ{rst_n}} & (NUM_REQ'(1) << win_idx);
                alu_a_d    = req_a[win_idx*DATA_W +: DATA_W];
                alu_b_d    = req_b[win_idx*DATA_W +: DATA_W];
                alu_ctrl_d = req_ctrl[win_idx*4 +: 4];
                id_d       = win_idx;
                state_d    = EXEC;
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = alu_data;
                rsp_carry_d = alu_carry;
                rsp_zero_d  = alu_zero;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, ALU operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;

    localparam int N = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [N*4-1:0]  req_ctrl;
    logic [31:0]     alu_a, alu_b, alu_data, rsp_data;
    logic [3:0]      alu_ctrl;
    logic            alu_carry, alu_zero, rsp_valid, rsp_ready, rsp_carry, rsp_zero;
    logic [1:0]      rsp_id;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_data(alu_data), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: {carry, zero, data}; carry is carry-out for ADD and borrow for SUB
    function automatic logic [33:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] d;
        logic        cy;
        s  = '0;
        d  = '0;
        cy = 1'b0;
        case (c)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; d = s[31:0]; cy = s[32]; end
            4'b1000: begin d = a - b; cy = (a < b); end
            4'b0001: d = a << b[4:0];
            4'b0010: d = {31'b0, $signed(a) < $signed(b)};
            4'b0011: d = {31'b0, a < b};
            4'b0100: d = a ^ b;
            4'b0101: d = a >> b[4:0];
            4'b0110: d = a | b;
            4'b0111: d = a & b;
            4'b1101: d = $signed(a) >>> b[4:0];
            default: d = '0;
        endcase
        return {cy, d == 32'd0, d};
    endfunction

    assign {alu_carry, alu_zero, alu_data} = alu_f(alu_ctrl, alu_a, alu_b);

    // Arbitration reference: first valid index searching from ptr_m with wrap
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return 0;
    endfunction

    task automatic adv(input int w);
        if (!FIXED) ptr_m = (w + 1) % N;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ctrl[i*4 +: 4] = c;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        set_req(0, 32'h1234, 32'h5678, 4'b0100);
        set_req(1, 32'h1, 32'h2, 4'b1000);
        @(negedge clk);
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin fails++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_a, alu_b, alu_ctrl); end
        tests++; if ({rsp_id, rsp_data, rsp_carry, rsp_zero} !== 36'd0) begin fails++; $display("FAIL reset_rsp: got id %0d data %h c %b z %b expected 0", rsp_id, rsp_data, rsp_carry, rsp_zero); end
        req_valid = '0;
        next();
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_add_wrap();
        set_req(0, 32'hFFFF_FFFF, 32'h1, 4'b0000);
        @(negedge clk);
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL add_grant: got %b expected 001", req_ready); end
        next();
        adv(0);
        req_valid = '0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin fails++; $display("FAIL add_exec: got rsp_valid %b req_ready %b expected 0 000", rsp_valid, req_ready); end
        tests++; if (alu_a !== 32'hFFFF_FFFF || alu_b !== 32'h1 || alu_ctrl !== 4'b0000) begin fails++; $display("FAIL add_issue: got %h %h %h", alu_a, alu_b, alu_ctrl); end
        next();
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 2'd0, 32'd0, 1'b1, 1'b1}) begin fails++; $display("FAIL add_rsp: got v %b id %0d data %h c %b z %b expected 1 0 0 1 1", rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero); end
        next();
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        set_req(0, 32'd10, 32'd1, 4'b0000);
        set_req(1, 32'd20, 32'd2, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            e = FIXED ? 0 : k % 2;
            @(negedge clk);
            tests++; if (req_ready !== 3'(1 << e)) begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 3'(1 << e)); end
            next();
            adv(e);
            @(negedge clk);
            tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rr_exec_ready%0d: got %b expected 000", k, req_ready); end
            next();
            @(negedge clk);
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || req_ready !== 3'b000) begin fails++; $display("FAIL rr_rsp%0d: got v %b id %0d ready %b expected 1 %0d 000", k, rsp_valid, rsp_id, req_ready, e); end
            next();
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        set_req(1, 32'd5, 32'd7, 4'b1000);
        @(negedge clk);
        tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL stall_grant: got %b expected 010", req_ready); end
        next();
        adv(1);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        next();
        set_req(0, 32'h8000_0000, 32'd4, 4'b1101);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, 2'd1, 32'hFFFF_FFFE, 1'b1}) begin fails++; $display("FAIL stall_hold%0d: got v %b id %0d data %h c %b", s, rsp_valid, rsp_id, rsp_data, rsp_carry); end
            tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL stall_ready%0d: got %b expected 000", s, req_ready); end
            next();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || req_ready !== 3'b000) begin fails++; $display("FAIL stall_handshake: got v %b ready %b expected 1 000", rsp_valid, req_ready); end
        next();
    endtask

    task automatic test_shift_compare();
        set_req(0, 32'h8000_0000, 32'd4, 4'b1101);
        @(negedge clk);
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL sra_grant: got %b expected 001", req_ready); end
        next();
        adv(0);
        req_valid = '0;
        next();
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 2'd0, 32'hF800_0000, 1'b0}) begin fails++; $display("FAIL sra_rsp: got v %b id %0d data %h z %b expected 1 0 f8000000 0", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        next();
        set_req(0, 32'd1, 32'd2, 4'b0011);
        @(negedge clk);
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL sltu_grant: got %b expected 001", req_ready); end
        next();
        adv(0);
        req_valid = '0;
        next();
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_data, rsp_zero} !== {1'b1, 32'd1, 1'b0}) begin fails++; $display("FAIL sltu_rsp: got v %b data %h z %b expected 1 1 0", rsp_valid, rsp_data, rsp_zero); end
        next();
    endtask

    task automatic test_reset_mid_exec();
        set_req(1, 32'hA5A5_0000, 32'h0000_5A5A, 4'b0100);
        @(negedge clk);
        tests++; if (req_ready !== 3'(1 << pick(3'b010))) begin fails++; $display("FAIL rst_mid_grant: got %b expected 010", req_ready); end
        next();
        set_req(0, 32'd3, 32'd3, 4'b1000);
        rst_n = 1'b0;
        #1;
        tests++; if ({req_ready, alu_a, alu_b, alu_ctrl} !== 71'd0) begin fails++; $display("FAIL rst_mid_issue: got %b %h %h %h expected 0", req_ready, alu_a, alu_b, alu_ctrl); end
        tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== 37'd0) begin fails++; $display("FAIL rst_mid_rsp: got v %b id %0d data %h expected 0", rsp_valid, rsp_id, rsp_data); end
        next();
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        tests++; if (req_ready !== 3'b001 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_release: got ready %b v %b expected 001 0", req_ready, rsp_valid); end
        next();
        adv(0);
        req_valid = '0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_stale: got v %b expected 0", rsp_valid); end
        next();
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 2'd0, 32'd0, 1'b1}) begin fails++; $display("FAIL rst_mid_first: got v %b id %0d data %h z %b expected 1 0 0 1", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        next();
    endtask

    task automatic test_idle_hold();
        logic [31:0] a, b;
        logic [3:0]  c;
        a = $urandom;
        b = $urandom;
        c = 4'($urandom_range(0, 15));
        set_req(2, a, b, c);
        @(negedge clk);
        tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL idle_grant: got %b expected 100", req_ready); end
        next();
        adv(2);
        req_valid = '0;
        next();
        next();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (req_ready !== 3'b000 || rsp_valid !== 1'b0) begin fails++; $display("FAIL idle%0d: got ready %b v %b expected 000 0", i, req_ready, rsp_valid); end
            tests++; if ({alu_a, alu_b, alu_ctrl} !== {a, b, c}) begin fails++; $display("FAIL idle_alu%0d: got %h %h %h expected %h %h %h", i, alu_a, alu_b, alu_ctrl, a, b, c); end
            next();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        logic [33:0]  ex;
        logic [31:0]  pa, pb;
        logic [3:0]   pc;
        int w, st;
        m = '0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++)
                if (!m[i] && $urandom_range(0, 1) == 1) begin
                    pa = $urandom;
                    pb = ($urandom_range(0, 3) == 0) ? pa : $urandom;
                    set_req(i, pa, pb, 4'($urandom_range(0, 15)));
                    m[i] = 1'b1;
                end
            if (m == '0) begin
                w = $urandom_range(0, N - 1);
                set_req(w, $urandom, $urandom, 4'b0000);
                m[w] = 1'b1;
            end
            req_valid = m;
            w = pick(m);
            pa = req_a[w*32 +: 32];
            pb = req_b[w*32 +: 32];
            pc = req_ctrl[w*4 +: 4];
            ex = alu_f(pc, pa, pb);
            @(negedge clk);
            tests++; if (req_ready !== 3'(1 << w)) begin fails++; $display("FAIL rnd_grant%0d: got %b expected %b", it, req_ready, 3'(1 << w)); end
            next();
            adv(w);
            m[w] = 1'b0;
            req_valid = m;
            st = $urandom_range(0, 3);
            rsp_ready = (st == 0);
            @(negedge clk);
            tests++; if ({alu_a, alu_b, alu_ctrl, req_ready, rsp_valid} !== {pa, pb, pc, 3'b000, 1'b0}) begin fails++; $display("FAIL rnd_issue%0d: got %h %h %h %b %b expected %h %h %h 000 0", it, alu_a, alu_b, alu_ctrl, req_ready, rsp_valid, pa, pb, pc); end
            next();
            for (int s = 0; s <= st; s++) begin
                rsp_ready = (s == st);
                @(negedge clk);
                tests++; if ({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_data, req_ready} !== {1'b1, 2'(w), ex, 3'b000}) begin fails++; $display("FAIL rnd_rsp%0d: got v %b id %0d c %b z %b data %h ready %b expected id %0d c %b z %b data %h", it, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_data, req_ready, w, ex[33], ex[32], ex[31:0]); end
                next();
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_add_wrap();
        test_round_robin();
        test_stall();
        test_shift_compare();
        test_reset_mid_exec();
        test_idle_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
